// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encodings and oversample sample points
// Holds the TX/RX FSM state enums and helpers that derive the RX sample ticks from OVS.
package uart_pkg;

    // Data bits per frame = cfg_bits + FRAME_MIN_BITS
    localparam int FRAME_MIN_BITS = 5;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // Start bit is checked one tick early because detection already cost
    // the synchroniser latency; all other bits are sampled at true mid-bit.
    function automatic int start_sample_pt(input int ovs);
        return ovs / 2 - 1;
    endfunction

    function automatic int mid_sample_pt(input int ovs);
        return ovs / 2;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - show-ahead synchronous buffer used for both UART directions
// Ports: clk, rst (async active-high); wr_tvalid/wr_tdata/wr_tready write side (wr_tready = not full);
//        rd_tvalid/rd_tdata/rd_tready read side (rd_tvalid = not empty, rd_tdata = head, zero when empty).
// DEPTH == 1 builds a single holding register; larger DEPTH must be a power of 2.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_tvalid,
    input  logic [WIDTH-1:0] wr_tdata,
    output logic             wr_tready,
    output logic             rd_tvalid,
    output logic [WIDTH-1:0] rd_tdata,
    input  logic             rd_tready
);

    logic rd_fire;
    logic wr_fire;

    assign rd_fire = rd_tvalid && rd_tready;
    // A pop in the same cycle frees the slot, so a full buffer still takes the write
    assign wr_fire = wr_tvalid && (wr_tready || rd_fire);

    generate
        if (DEPTH == 1) begin : g_hold
            logic             full_q;
            logic [WIDTH-1:0] hold_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    full_q <= 1'b0;
                    hold_q <= '0;
                end else if (wr_fire) begin
                    full_q <= 1'b1;
                    hold_q <= wr_tdata;
                end else if (rd_fire) begin
                    full_q <= 1'b0;
                end
            end

            assign wr_tready = !full_q;
            assign rd_tvalid = full_q;
            assign rd_tdata  = full_q ? hold_q : '0;
        end else begin : g_ring
            localparam int AW = $clog2(DEPTH);

            // Extra MSB on each pointer distinguishes full from empty
            logic [AW:0]      wptr;
            logic [AW:0]      rptr;
            logic [WIDTH-1:0] mem [DEPTH];
            logic             empty;

            assign empty     = (wptr == rptr);
            assign wr_tready = !((wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]));
            assign rd_tvalid = !empty;
            assign rd_tdata  = empty ? '0 : mem[rptr[AW-1:0]];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    wptr <= '0;
                    rptr <= '0;
                end else begin
                    if (wr_fire) wptr <= wptr + (AW+1)'(1);
                    if (rd_fire) rptr <= rptr + (AW+1)'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (wr_fire) mem[wptr[AW-1:0]] <= wr_tdata;
            end
        end
    endgenerate

endmodule

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - buffered UART transmitter/receiver with programmable frame format
// Build option UART_FIFO_EN: TX and RX buffers are FIFO_DEPTH-entry FIFOs; otherwise single holding registers.
// Ports: clk, rst (async active-high); baud_div (tick every baud_div+1 clocks);
//        cfg_bits/cfg_par_en/cfg_par_odd/cfg_stop2 frame format, latched at each frame start;
//        tx_valid/tx_data/tx_ready write port; rx_valid/rx_data/rx_perr/rx_ferr/rx_ready show-ahead read port;
//        txd/rxd serial lines; tx_busy; overrun sticky flag with overrun_clr.
module uart_fifo #(
    parameter int DATA_W     = 8,
    parameter int OVS        = 16,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic [1:0]        cfg_bits,
    input  logic              cfg_par_en,
    input  logic              cfg_par_odd,
    input  logic              cfg_stop2,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_perr,
    output logic              rx_ferr,
    input  logic              rx_ready,
    output logic              txd,
    input  logic              rxd,
    output logic              tx_busy,
    output logic              overrun,
    input  logic              overrun_clr
);
    import uart_pkg::*;

`ifdef UART_FIFO_EN
    localparam int BUF_DEPTH = FIFO_DEPTH;
`else
    // Single holding register; FIFO_DEPTH has no effect in this build
    localparam int BUF_DEPTH = (FIFO_DEPTH > 0) ? 1 : 1;
`endif
    localparam int             TCW     = $clog2(OVS);
    localparam logic [TCW-1:0] T_START = TCW'(start_sample_pt(OVS));
    localparam logic [TCW-1:0] T_MID   = TCW'(mid_sample_pt(OVS));
    localparam logic [TCW-1:0] T_LAST  = TCW'(OVS - 1);

    // Baud tick; >= keeps the counter from running to wrap if baud_div shrinks
    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    assign tick = (div_cnt >= baud_div);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) div_cnt <= '0;
        else     div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
    end

    // Mask of the data bits in use for the current cfg_bits
    logic [DATA_W-1:0] cfg_mask;
    always_comb begin
        cfg_mask = '0;
        for (int i = 0; i < DATA_W; i++) cfg_mask[i] = (i < int'(cfg_bits) + FRAME_MIN_BITS);
    end

    // ---------------- TX ----------------
    logic              txf_valid;
    logic [DATA_W-1:0] txf_data;
    logic              tx_pop;
    tx_state_t         tx_state;
    logic [TCW-1:0]    tx_tc;
    logic [2:0]        tx_bit;
    logic [2:0]        tx_last;
    logic [DATA_W-1:0] tx_sh;
    logic              tx_par;
    logic              tx_par_en;
    logic              tx_stop2;
    logic              tx_stop_2nd;

    uart_sync_fifo #(.WIDTH(DATA_W), .DEPTH(BUF_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_tvalid (tx_valid),
        .wr_tdata  (tx_data),
        .wr_tready (tx_ready),
        .rd_tvalid (txf_valid),
        .rd_tdata  (txf_data),
        .rd_tready (tx_pop)
    );

    assign tx_pop  = (tx_state == TX_IDLE) && txf_valid;
    assign tx_busy = (tx_state != TX_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state    <= TX_IDLE;
            tx_tc       <= '0;
            tx_bit      <= '0;
            tx_last     <= '0;
            tx_sh       <= '0;
            tx_par      <= 1'b0;
            tx_par_en   <= 1'b0;
            tx_stop2    <= 1'b0;
            tx_stop_2nd <= 1'b0;
            txd         <= 1'b1;
        end else begin
            // txd is the registered image of the current state, one clock behind it
            case (tx_state)
                TX_START:  txd <= 1'b0;
                TX_DATA:   txd <= tx_sh[0];
                TX_PARITY: txd <= tx_par;
                default:   txd <= 1'b1;
            endcase

            if (tx_pop) begin
                tx_sh       <= txf_data & cfg_mask;
                tx_par      <= (^(txf_data & cfg_mask)) ^ cfg_par_odd;
                tx_last     <= {1'b0, cfg_bits} + 3'd4;
                tx_par_en   <= cfg_par_en;
                tx_stop2    <= cfg_stop2;
                tx_tc       <= '0;
                tx_bit      <= '0;
                tx_stop_2nd <= 1'b0;
                tx_state    <= TX_START;
            end else if (tx_state != TX_IDLE && tick) begin
                tx_tc <= (tx_tc == T_LAST) ? '0 : tx_tc + TCW'(1);
                if (tx_tc == T_LAST) begin
                    case (tx_state)
                        TX_START: tx_state <= TX_DATA;
                        TX_DATA: begin
                            tx_sh  <= tx_sh >> 1;
                            tx_bit <= tx_bit + 3'd1;
                            if (tx_bit == tx_last) tx_state <= tx_par_en ? TX_PARITY : TX_STOP;
                        end
                        TX_PARITY: tx_state <= TX_STOP;
                        TX_STOP: begin
                            if (tx_stop2 && !tx_stop_2nd) tx_stop_2nd <= 1'b1;
                            else                          tx_state    <= TX_IDLE;
                        end
                        default: tx_state <= TX_IDLE;
                    endcase
                end
            end
        end
    end

    // ---------------- RX ----------------
    logic              rx_meta;
    logic              rx_sync;
    logic              rx_prev;
    rx_state_t         rx_state;
    logic [TCW-1:0]    rx_tc;
    logic [2:0]        rx_bit;
    logic [2:0]        rx_last;
    logic              rx_par_en;
    logic              rx_par_odd;
    logic [DATA_W-1:0] rx_sh;
    logic              rx_perr_q;
    logic              rx_push;
    logic              rxf_ready;
    logic              rx_pop;
    logic [DATA_W+1:0] rxf_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign rx_push = (rx_state == RX_STOP) && tick && (rx_tc == T_MID);
    assign rx_pop  = rx_valid && rx_ready;

    uart_sync_fifo #(.WIDTH(DATA_W + 2), .DEPTH(BUF_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_tvalid (rx_push),
        .wr_tdata  ({~rx_sync, rx_perr_q, rx_sh}),
        .wr_tready (rxf_ready),
        .rd_tvalid (rx_valid),
        .rd_tdata  (rxf_data),
        .rd_tready (rx_ready)
    );

    assign {rx_ferr, rx_perr, rx_data} = rxf_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state   <= RX_IDLE;
            rx_tc      <= '0;
            rx_bit     <= '0;
            rx_last    <= '0;
            rx_par_en  <= 1'b0;
            rx_par_odd <= 1'b0;
            rx_sh      <= '0;
            rx_perr_q  <= 1'b0;
        end else if (rx_state == RX_IDLE) begin
            if (rx_prev && !rx_sync) begin
                rx_last    <= {1'b0, cfg_bits} + 3'd4;
                rx_par_en  <= cfg_par_en;
                rx_par_odd <= cfg_par_odd;
                rx_tc      <= '0;
                rx_bit     <= '0;
                rx_sh      <= '0;
                rx_perr_q  <= 1'b0;
                rx_state   <= RX_START;
            end
        end else if (tick) begin
            rx_tc <= (rx_tc == T_LAST) ? '0 : rx_tc + TCW'(1);
            case (rx_state)
                RX_START: begin
                    if (rx_tc == T_START && rx_sync) rx_state <= RX_IDLE;
                    else if (rx_tc == T_LAST)        rx_state <= RX_DATA;
                end
                RX_DATA: begin
                    if (rx_tc == T_MID) begin
                        for (int i = 0; i < DATA_W; i++)
                            if (i == int'(rx_bit)) rx_sh[i] <= rx_sync;
                    end
                    if (rx_tc == T_LAST) begin
                        rx_bit <= rx_bit + 3'd1;
                        if (rx_bit == rx_last) rx_state <= rx_par_en ? RX_PARITY : RX_STOP;
                    end
                end
                RX_PARITY: begin
                    if (rx_tc == T_MID)  rx_perr_q <= rx_sync ^ (^rx_sh) ^ rx_par_odd;
                    if (rx_tc == T_LAST) rx_state  <= RX_STOP;
                end
                RX_STOP: if (rx_tc == T_MID) rx_state <= RX_IDLE;
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Set wins over clear; a push that coincides with a pop is not an overrun
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                   overrun <= 1'b0;
        else if (rx_push && !rxf_ready && !rx_pop) overrun <= 1'b1;
        else if (overrun_clr)                      overrun <= 1'b0;
    end

endmodule

// File: tb/tb_uart_fifo.sv
// tb/tb_uart_fifo.sv - directed self-checking bench for uart_fifo
module tb_uart_fifo;
    localparam int DATA_W     = 8;
    localparam int OVS        = 16;
    localparam int DIV_W      = 16;
    localparam int FIFO_DEPTH = 8;
`ifdef UART_FIFO_EN
    localparam int DEPTH_EFF = FIFO_DEPTH;
`else
    localparam int DEPTH_EFF = 1;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DIV_W-1:0]  baud_div = 16'd3;
    logic [1:0]        cfg_bits = 2'd3;
    logic              cfg_par_en = 1'b0;
    logic              cfg_par_odd = 1'b0;
    logic              cfg_stop2 = 1'b0;
    logic              tx_valid = 1'b0;
    logic [DATA_W-1:0] tx_data = '0;
    logic              tx_ready;
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic              rx_perr;
    logic              rx_ferr;
    logic              rx_ready = 1'b0;
    logic              txd;
    logic              rxd;
    logic              rxd_drv = 1'b1;
    logic              loop = 1'b0;
    logic              tx_busy;
    logic              overrun;
    logic              overrun_clr = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    assign rxd = loop ? txd : rxd_drv;

    always #5 clk = ~clk;

    uart_fifo #(.DATA_W(DATA_W), .OVS(OVS), .DIV_W(DIV_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .baud_div    (baud_div),
        .cfg_bits    (cfg_bits),
        .cfg_par_en  (cfg_par_en),
        .cfg_par_odd (cfg_par_odd),
        .cfg_stop2   (cfg_stop2),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_perr     (rx_perr),
        .rx_ferr     (rx_ferr),
        .rx_ready    (rx_ready),
        .txd         (txd),
        .rxd         (rxd),
        .tx_busy     (tx_busy),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input logic v, input int n);
        @(negedge clk);
        rxd_drv = v;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nb, input logic pen,
                              input logic podd, input logic stop_v, input logic flip_par);
        int   bp;
        logic p;
        bp = (int'(baud_div) + 1) * OVS;
        p  = podd;
        drive_bit(1'b0, bp);
        for (int i = 0; i < nb; i++) begin
            drive_bit(d[i], bp);
            p = p ^ d[i];
        end
        if (pen) drive_bit(p ^ flip_par, bp);
        drive_bit(stop_v, bp);
        drive_bit(1'b1, 2 * bp);
    endtask

    task automatic wait_rx(input string tag);
        int n;
        n = 0;
        while (!rx_valid && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(tag, rx_valid, 1);
    endtask

    task automatic pop_rx();
        @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic write_tx(input logic [7:0] d);
        int n;
        n = 0;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = d;
        while (!tx_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("tx_accept", tx_ready, 1);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] frame;
        logic       bit_ok [10];
        int         busy_cnt;
        logic [7:0] d;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_txd", txd, 1);
        check("rst_tx_busy", tx_busy, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_perr", rx_perr, 0);
        check("rst_rx_ferr", rx_ferr, 0);
        check("rst_overrun", overrun, 0);

        // 8N1 0xA5 at baud_div=3; write lands one edge before a tick edge so every bit is 64 clocks
        rst = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        @(negedge clk);
        tx_valid = 1'b0;
        check("busy_after_accept", tx_busy, 0);
        frame    = {1'b1, 8'hA5, 1'b0};
        busy_cnt = 0;
        for (int b = 0; b < 10; b++) bit_ok[b] = 1'b1;
        for (int j = 0; j < 700; j++) begin
            @(negedge clk);
            if (tx_busy) busy_cnt++;
            if (j == 0) check("txd_n1", txd, 1);
            if (j == 1) check("txd_n2_start", txd, 0);
            if (j >= 1 && j <= 640 && txd !== frame[(j - 1) / 64]) bit_ok[(j - 1) / 64] = 1'b0;
        end
        for (int b = 0; b < 10; b++) check($sformatf("a5_bit%0d", b), bit_ok[b], 1);
        check("a5_busy_clocks", busy_cnt, 640);
        check("a5_idle_txd", txd, 1);

        // Loopback 7O2 0x35; cfg change mid-frame must not disturb it
        baud_div   = 16'd0;
        loop       = 1'b1;
        cfg_bits   = 2'd2;
        cfg_par_en = 1'b1;
        cfg_par_odd = 1'b1;
        cfg_stop2  = 1'b1;
        write_tx(8'h35);
        repeat (50) @(negedge clk);
        cfg_bits   = 2'd3;
        cfg_par_en = 1'b0;
        cfg_par_odd = 1'b0;
        cfg_stop2  = 1'b0;
        wait_rx("lb_valid");
        check("lb_data", rx_data, 8'h35);
        check("lb_perr", rx_perr, 0);
        check("lb_ferr", rx_ferr, 0);
        pop_rx();
        check("lb_empty", rx_valid, 0);
        repeat (100) @(negedge clk);
        loop = 1'b0;

        // 8E1: bad parity frame, then bad stop frame
        cfg_par_en = 1'b1;
        send_frame(8'h3C, 8, 1'b1, 1'b0, 1'b1, 1'b1);
        wait_rx("perr_valid");
        check("perr_data", rx_data, 8'h3C);
        check("perr_perr", rx_perr, 1);
        check("perr_ferr", rx_ferr, 0);
        pop_rx();
        send_frame(8'h11, 8, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_rx("ferr_valid");
        check("ferr_data", rx_data, 8'h11);
        check("ferr_perr", rx_perr, 0);
        check("ferr_ferr", rx_ferr, 1);
        pop_rx();
        check("ferr_empty", rx_valid, 0);

        // False start: 4-tick low glitch, then a good 8N1 frame
        cfg_par_en = 1'b0;
        @(negedge clk);
        rxd_drv = 1'b0;
        repeat (4) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (48) @(negedge clk);
        check("glitch_no_push", rx_valid, 0);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_rx("after_glitch_valid");
        check("after_glitch_data", rx_data, 8'h5A);
        check("after_glitch_ferr", rx_ferr, 0);
        pop_rx();

        // Overrun: one frame more than the buffer holds, nothing popped
        for (int i = 0; i <= DEPTH_EFF; i++) begin
            d = 8'h40 + 8'(i);
            send_frame(d, 8, 1'b0, 1'b0, 1'b1, 1'b0);
            if (i == DEPTH_EFF - 1) check("ovr_not_yet", overrun, 0);
        end
        check("ovr_set", overrun, 1);
        for (int i = 0; i < DEPTH_EFF; i++) begin
            d = 8'h40 + 8'(i);
            check($sformatf("ovr_keep%0d", i), rx_data, d);
            pop_rx();
        end
        check("ovr_drained", rx_valid, 0);
        check("ovr_sticky", overrun, 1);
        @(negedge clk);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        check("ovr_cleared", overrun, 0);

        // Reset mid-DATA with words buffered in both directions
        send_frame(8'h77, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_rx("pre_rst_rx_valid");
        write_tx(8'h00);
        for (int i = 0; i < DEPTH_EFF; i++) write_tx(8'hFF);
        check("tx_full", tx_ready, 0);
        repeat (40) @(negedge clk);
        check("pre_rst_busy", tx_busy, 1);
        check("pre_rst_txd", txd, 0);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_txd", txd, 1);
        check("rst_mid_tx_ready", tx_ready, 1);
        check("rst_mid_rx_valid", rx_valid, 0);
        check("rst_mid_busy", tx_busy, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        check("post_rst_txd", txd, 1);
        check("post_rst_busy", tx_busy, 0);
        check("post_rst_rx_valid", rx_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_fifo.md
UART_FIFO -- requirements
Module: uart_fifo

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8: maximum data bits per frame, with 5 <= DATA_W <= 8.
REQ-002 The block SHALL have parameter OVS, default 16: oversample ticks per bit; it SHALL be even and >= 8.
REQ-003 The block SHALL have parameter DIV_W, default 16: width of the baud divisor.
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 8: entries per FIFO; it SHALL be a power of 2 and >= 2.
REQ-005 The block SHALL use reset rst, asynchronous, active-high; clock clk.
REQ-006 Port clk, input, 1 bit: clock.
REQ-007 Port rst, input, 1 bit: asynchronous active-high reset.
REQ-008 Port baud_div, input, DIV_W bits: one tick is produced every baud_div+1 clocks.
REQ-009 Port cfg_bits, input, 2 bits: data bits per frame = cfg_bits+5.
REQ-010 Port cfg_par_en, input, 1 bit: parity enable. Port cfg_par_odd, input, 1 bit: odd parity. Port cfg_stop2, input, 1 bit: two stop bits.
REQ-011 Port tx_valid, input, 1 bit; port tx_data, input, DATA_W bits; port tx_ready, output, 1 bit: valid/ready write port into the TX buffer.
REQ-012 Port rx_valid, output, 1 bit; port rx_data, output, DATA_W bits; port rx_perr, output, 1 bit; port rx_ferr, output, 1 bit; port rx_ready, input, 1 bit: valid/ready read port from the RX buffer.
REQ-013 Port txd, output, 1 bit: serial out. Port rxd, input, 1 bit: serial in, asynchronous to clk.
REQ-014 Port tx_busy, output, 1 bit: frame in progress. Port overrun, output, 1 bit: sticky overrun flag. Port overrun_clr, input, 1 bit: clears overrun.

Function
REQ-015 The tick counter SHALL count 0..baud_div and pulse tick for one clock at baud_div; baud_div=0 SHALL give a tick every clock.
REQ-016 A TX write SHALL be accepted on a cycle with tx_valid && tx_ready; tx_ready SHALL equal "TX buffer not full".
REQ-017 The TX FSM SHALL use states IDLE, START, DATA, PARITY, STOP, each bit lasting OVS ticks.
REQ-018 In IDLE with the buffer non-empty, the TX FSM SHALL pop one word, latch the cfg_* inputs, and enter START; for a write accepted at edge N into an empty, idle block, txd SHALL be 0 after edge N+2.
REQ-019 TX SHALL send data LSB first, cfg_bits+5 bits; SHALL send PARITY only if cfg_par_en, as XOR of the data bits, inverted when cfg_par_odd; SHALL send 1 stop bit, or 2 if cfg_stop2. The txd output SHALL be registered.
REQ-020 A change to cfg_* mid-frame SHALL NOT affect the current TX or RX frame; both FSMs latch cfg_* at frame start.
REQ-021 rxd SHALL pass through a 2-flop synchroniser reset to 1; RX SHALL detect a start on a synchronised 1->0 edge.
REQ-022 RX SHALL sample at tick OVS/2-1 of the start bit and return to IDLE without a push if the sample is 1 (false start).
REQ-023 RX SHALL sample data and parity bits at tick OVS/2 of each bit and assemble data LSB first, zero-extending unused upper bits.
REQ-024 RX SHALL sample only the first stop bit, at mid-bit, then push {ferr = stop sample is 0, perr = parity mismatch, data} and return to IDLE at the same edge.
REQ-025 A push into a full RX buffer SHALL drop the word and set overrun; a simultaneous pop and push on a full buffer SHALL accept the push and SHALL NOT set overrun.
REQ-026 The RX port SHALL be show-ahead: rx_valid = "not empty", rx_data/rx_perr/rx_ferr present the head entry, and rx_valid && rx_ready pops.
REQ-027 overrun_clr SHALL clear overrun; if set and clear coincide, set SHALL win.
REQ-028 tx_busy SHALL be 1 whenever the TX FSM is not in IDLE.
REQ-029 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits and wrap without loss.

Reset
REQ-030 During rst: txd=1, tx_busy=0, tx_ready=1, rx_valid=0, rx_data=0, rx_perr=0, rx_ferr=0, overrun=0, both FIFOs empty, both FSMs in IDLE, tick counter 0.
REQ-031 Reset mid-frame SHALL abort the frame immediately, drive txd to 1, and discard all buffered words.

Configuration
REQ-032 With UART_FIFO_EN defined, the TX and RX buffers SHALL each be FIFOs of FIFO_DEPTH entries.
REQ-033 Without UART_FIFO_EN, each buffer SHALL be a single holding register with identical port semantics, and FIFO_DEPTH SHALL be ignored.

Structure
REQ-034 Package uart_pkg SHALL hold the TX/RX state enums and the sample-point constants derived from OVS.
REQ-035 Sub-module uart_sync_fifo (parameters WIDTH, DEPTH) SHALL implement both FIFOs and be instantiated twice.

Verification
REQ-036 Scenario: baud_div=3, 8N1, write 0xA5 -> txd = 0,1,0,1,0,0,1,0,1,1, each bit 64 clocks; tx_busy high for 640 clocks.
REQ-037 Scenario: txd looped to rxd, 7O2, send 0x35 -> pop rx_data=0x35, rx_perr=0, rx_ferr=0.
REQ-038 Scenario: rxd frame 0x3C with wrong even parity, then a frame 0x11 with stop=0 -> entries {0x3C, perr=1, ferr=0} and {0x11, perr=0, ferr=1}.
REQ-039 Scenario: rx_ready=0, receive FIFO_DEPTH+1 frames -> first FIFO_DEPTH words retained in order, overrun=1; overrun_clr pulse -> overrun=0.
REQ-040 Scenario: rxd low pulse of 4 ticks -> no push, RX back in IDLE.
REQ-041 Scenario: rst asserted mid-DATA -> txd=1 within the same cycle, tx_ready=1, rx_valid=0.
